// File: rtl/risp_ctrl_pkg.sv
// Shared command/state types for the RISP step controller.
// RISP_STEP_CTRL_TIMESTAMP_EN widens each step record by a 32-bit step timestamp.
package risp_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_SPIKE = 2'd1,
        CMD_RUN   = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_CAPTURE,
        ST_DRAIN,
        ST_FLUSH
    } ctrl_state_t;

    localparam int TIMESTAMP_WIDTH = 32;

`ifdef RISP_STEP_CTRL_TIMESTAMP_EN
    localparam int TS_EXTRA = TIMESTAMP_WIDTH;
`else
    localparam int TS_EXTRA = 0;
`endif

endpackage

// File: rtl/risp_step_counter.sv
// Loadable down-counter shared by RUN step counting and CLEAR flushing.
// Saturates at zero; zero/last flags let the FSM leave before any wrap.
module risp_step_counter
    import risp_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             last
);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/risp_step_controller.sv
// Host-facing timestep sequencer for a RISP network: spike injection, stepping, flush, result stream.
// Define RISP_STEP_CTRL_TIMESTAMP_EN to prefix each record with a 32-bit RUN step timestamp.
//
// state      | meaning
// IDLE       | accepting host commands, accumulating pending spikes
// STEP       | one net_en strobe carrying the pending spikes
// CAPTURE    | network fire vector registered into out_data
// DRAIN      | out_valid held until host takes the record
// FLUSH      | net_en every cycle with no input to empty in-flight synapse state
module risp_step_controller
    import risp_ctrl_pkg::*;
#(
    parameter int NUM_INP     = 8,
    parameter int NUM_OUT     = 8,
    parameter int RUN_WIDTH   = 16,
    parameter int FLUSH_STEPS = 16
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [RUN_WIDTH-1:0]        cmd_arg,
    output logic                        net_en,
    output logic [NUM_INP-1:0]          net_inp,
    input  logic [NUM_OUT-1:0]          net_fire,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_OUT+TS_EXTRA-1:0] out_data,
    output logic                        busy,
    output logic                        done
);

    if (RUN_WIDTH < $clog2(NUM_INP)) begin : g_bad_run_width
        $error("RUN_WIDTH cannot address every input neuron");
    end
    if (FLUSH_STEPS < 1 || FLUSH_STEPS >= (2 ** RUN_WIDTH)) begin : g_bad_flush
        $error("FLUSH_STEPS must be at least 1 and fit in RUN_WIDTH");
    end

    ctrl_state_t                 state_q, state_d;
    logic [NUM_INP-1:0]          pending_q;
    logic [NUM_INP-1:0]          spike_mask;
    logic [NUM_OUT+TS_EXTRA-1:0] capture_val;
    logic [RUN_WIDTH-1:0]        cnt_val, cnt_count;
    logic                        cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic                        pend_set, pend_clr, capture, run_zero, done_now, done_q;

    risp_step_counter #(.WIDTH(RUN_WIDTH)) u_counter (
        .clk      (clk),
        .arstn    (arstn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // Out-of-range indices shift the one-hot bit out entirely, so they are ignored.
    assign spike_mask = NUM_INP'(1) << cmd_arg;

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        net_en    = 1'b0;
        out_valid = 1'b0;
        done_now  = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = cmd_arg;
        cnt_dec   = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        capture   = 1'b0;
        run_zero  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    unique case (cmd_op_t'(cmd_op))
                        CMD_SPIKE: pend_set = 1'b1;
                        CMD_RUN: begin
                            if (cmd_arg == '0) begin
                                run_zero = 1'b1;
                            end else begin
                                cnt_load = 1'b1;
                                state_d  = ST_STEP;
                            end
                        end
                        CMD_CLEAR: begin
                            cnt_load = 1'b1;
                            cnt_val  = RUN_WIDTH'(FLUSH_STEPS);
                            pend_clr = 1'b1;
                            state_d  = ST_FLUSH;
                        end
                        default: ;
                    endcase
                end
            end
            ST_STEP: begin
                net_en   = 1'b1;
                pend_clr = 1'b1;
                cnt_dec  = 1'b1;
                state_d  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt_zero) begin
                        done_now = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_STEP;
                    end
                end
            end
            ST_FLUSH: begin
                net_en  = 1'b1;
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    done_now = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            out_data  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= run_zero;
            if (pend_clr) begin
                pending_q <= '0;
            end else if (pend_set) begin
                pending_q <= pending_q | spike_mask;
            end
            if (capture) begin
                out_data <= capture_val;
            end
        end
    end

`ifdef RISP_STEP_CTRL_TIMESTAMP_EN
    logic [TIMESTAMP_WIDTH-1:0] ts_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ts_q <= '0;
        end else if (state_q == ST_STEP) begin
            ts_q <= ts_q + TIMESTAMP_WIDTH'(1);
        end
    end

    // ts_q has already advanced past the step being captured.
    assign capture_val = {ts_q - TIMESTAMP_WIDTH'(1), net_fire};
`else
    assign capture_val = net_fire;
`endif

    assign net_inp = (state_q == ST_STEP) ? pending_q : '0;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q | done_now;

endmodule

// File: tb/tb_risp_step_controller.sv
// Self-checking bench for risp_step_controller with a registered network stub and record scoreboard.
// Build with RISP_STEP_CTRL_TIMESTAMP_EN defined to also check record timestamps.
module tb_risp_step_controller;
    import risp_ctrl_pkg::*;

    localparam int NUM_INP     = 8;
    localparam int NUM_OUT     = 8;
    localparam int RUN_WIDTH   = 16;
    localparam int FLUSH_STEPS = 16;
    localparam int OUT_W       = NUM_OUT + TS_EXTRA;

    logic                 clk = 1'b0;
    logic                 arstn = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [1:0]           cmd_op = 2'd0;
    logic [RUN_WIDTH-1:0] cmd_arg = '0;
    logic                 net_en;
    logic [NUM_INP-1:0]   net_inp;
    logic [NUM_OUT-1:0]   net_fire;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [OUT_W-1:0]     out_data;
    logic                 busy;
    logic                 done;

    int n_chk = 0;
    int n_err = 0;

    logic [OUT_W-1:0] sb[$];
    int en_cnt = 0, valid_cnt = 0, done_cnt = 0, rec_cnt = 0;
    int inp_bad = 0, en_valid_bad = 0, unstable = 0;
    logic [NUM_INP-1:0] last_inp = '0;
    logic               hold_q = 1'b0;
    logic [OUT_W-1:0]   hold_data = '0;

    int                 net_steps;
    int                 model_steps = 0;
    int                 model_ts = 0;
    logic [NUM_INP-1:0] model_pend = '0;

    risp_step_controller #(
        .NUM_INP     (NUM_INP),
        .NUM_OUT     (NUM_OUT),
        .RUN_WIDTH   (RUN_WIDTH),
        .FLUSH_STEPS (FLUSH_STEPS)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .net_en    (net_en),
        .net_inp   (net_inp),
        .net_fire  (net_fire),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_OUT-1:0] fire_fn(input int k, input logic [NUM_INP-1:0] inp);
        logic [NUM_OUT-1:0] v;
        v = NUM_OUT'(k * 29 + 90);
        return v ^ NUM_OUT'(inp);
    endfunction

    // Network stub: fire vector registered one cycle after each net_en.
    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            net_fire  <= '0;
            net_steps <= 0;
        end else if (net_en) begin
            net_fire  <= fire_fn(net_steps, net_inp);
            net_steps <= net_steps + 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (net_en) begin
                en_cnt++;
                last_inp = net_inp;
                if (out_valid) en_valid_bad++;
            end else if (net_inp != '0) begin
                inp_bad++;
            end
            if (done) done_cnt++;
            if (out_valid) begin
                valid_cnt++;
                if (hold_q && (out_data !== hold_data)) unstable++;
                if (out_ready) begin
                    rec_cnt++;
                    if (sb.size() == 0) chk("sb_nonempty", 64'(sb.size()), 1);
                    else chk("record", out_data, sb.pop_front());
                end
            end
            hold_q    = out_valid && !out_ready;
            hold_data = out_data;
        end
    end

    task automatic model_accept(input cmd_op_t op, input int arg);
        logic [NUM_OUT-1:0] f;
        logic [OUT_W-1:0]   e;
        case (op)
            CMD_SPIKE: if (arg < NUM_INP) model_pend[arg] = 1'b1;
            CMD_RUN: begin
                for (int i = 0; i < arg; i++) begin
                    f = fire_fn(model_steps + i, (i == 0) ? model_pend : '0);
`ifdef RISP_STEP_CTRL_TIMESTAMP_EN
                    e = {TIMESTAMP_WIDTH'(model_ts + i), f};
`else
                    e = f;
`endif
                    sb.push_back(e);
                end
                model_steps += arg;
                model_ts    += arg;
                if (arg > 0) model_pend = '0;
            end
            CMD_CLEAR: begin
                model_steps += FLUSH_STEPS;
                model_pend   = '0;
            end
            default: ;
        endcase
    endtask

    task automatic send_cmd(input cmd_op_t op, input int arg);
        int k;
        k = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = RUN_WIDTH'(arg);
        do begin
            @(negedge clk);
            k++;
        end while (!cmd_ready && k < 200);
        chk("cmd_ready", cmd_ready, 1);
        @(posedge clk);
        model_accept(op, arg);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = '0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 500);
        chk(tag, busy, 0);
    endtask

    task automatic model_reset();
        sb.delete();
        model_steps = 0;
        model_ts    = 0;
        model_pend  = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog n_chk=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, e0, v0, d0, r0, bad, nr;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_net_en", net_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk);
        #1 arstn = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);

        // Spikes on inputs 2 and 5 then a single step
        e0 = en_cnt;
        send_cmd(CMD_SPIKE, 2);
        send_cmd(CMD_SPIKE, 5);
        send_cmd(CMD_RUN, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 20);
        chk("s1_latency", k, 3);
        chk("s1_done_on_hs", done, 1);
        #1;
        chk("s1_inp", last_inp, 8'h24);
        chk("s1_en_count", en_cnt - e0, 1);
        wait_idle("s1_idle");

        // Four steps with a 10-cycle stall on every record
        @(posedge clk);
        #1 out_ready = 1'b0;
        e0 = en_cnt; r0 = rec_cnt; d0 = done_cnt;
        send_cmd(CMD_RUN, 4);
        for (int r = 0; r < 4; r++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!out_valid && k < 50);
            chk("s2_valid", out_valid, 1);
            repeat (10) @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        wait_idle("s2_idle");
        #1;
        chk("s2_en_count", en_cnt - e0, 4);
        chk("s2_records", rec_cnt - r0, 4);
        chk("s2_done_count", done_cnt - d0, 1);
        chk("s2_sb_empty", 64'(sb.size()), 0);
        @(posedge clk);
        #1 out_ready = 1'b1;

        // RUN 0, then an out-of-range spike
        e0 = en_cnt; v0 = valid_cnt; d0 = done_cnt;
        send_cmd(CMD_RUN, 0);
        @(negedge clk);
        chk("s3_done_next", done, 1);
        repeat (5) @(negedge clk);
        #1;
        chk("s3_en_none", en_cnt - e0, 0);
        chk("s3_valid_none", valid_cnt - v0, 0);
        chk("s3_done_count", done_cnt - d0, 1);
        send_cmd(CMD_SPIKE, 9);
        send_cmd(CMD_RUN, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!net_en && k < 20);
        chk("s3_en_seen", net_en, 1);
        #1;
        chk("s3_inp_zero", last_inp, 0);
        wait_idle("s3_idle");

        // CLEAR discards a pending spike and flushes FLUSH_STEPS steps
        send_cmd(CMD_SPIKE, 3);
        e0 = en_cnt; v0 = valid_cnt;
        send_cmd(CMD_CLEAR, 0);
        k = 0; bad = 0; nr = 0;
        do begin
            @(negedge clk);
            k++;
            if (net_en && (net_inp != '0)) bad++;
            if (cmd_ready) nr++;
        end while (!done && k < 40);
        chk("s4_done_cycle", k, FLUSH_STEPS);
        #1;
        chk("s4_en_count", en_cnt - e0, FLUSH_STEPS);
        chk("s4_inp_zero", bad, 0);
        chk("s4_ready_low", nr, 0);
        @(negedge clk);
        #1;
        chk("s4_valid_none", valid_cnt - v0, 0);
        chk("s4_idle", busy, 0);
        send_cmd(CMD_RUN, 1);
        wait_idle("s4_run_idle");

        // Reset during step 3 of RUN 10
        e0 = en_cnt;
        send_cmd(CMD_RUN, 10);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while ((en_cnt - e0) < 3 && k < 100);
        chk("s5_en_before_rst", en_cnt - e0, 3);
        arstn = 1'b0;
        #1;
        chk("s5_rst_net_en", net_en, 0);
        chk("s5_rst_out_valid", out_valid, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_done", done, 0);
        chk("s5_rst_out_data", out_data, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
        @(negedge clk);
        chk("s5_cmd_ready", cmd_ready, 1);
        r0 = rec_cnt;
        send_cmd(CMD_RUN, 1);
        wait_idle("s5_idle");
        #1;
        chk("s5_records", rec_cnt - r0, 1);

        // Timestamps advance only on RUN steps
        @(posedge clk);
        #1 arstn = 1'b0;
        model_reset();
        @(posedge clk);
        #1 arstn = 1'b1;
        r0 = rec_cnt;
        send_cmd(CMD_RUN, 3);
        wait_idle("s6_run3_idle");
        send_cmd(CMD_CLEAR, 0);
        wait_idle("s6_clear_idle");
        send_cmd(CMD_RUN, 2);
        wait_idle("s6_run2_idle");
        #1;
        chk("s6_records", rec_cnt - r0, 5);
        chk("s6_sb_empty", 64'(sb.size()), 0);

        chk("inp_without_en", inp_bad, 0);
        chk("en_during_valid", en_valid_bad, 0);
        chk("stall_stable", unstable, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
